// File: rtl/cdc_hs_pkg.sv
// Shared definitions for the four-phase handshake source controller.
// Holds the FSM state type, the default parameters and the wait-counter width helper.
package cdc_hs_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      RELEASE = 2'd2,
      ERR     = 2'd3
   } cdc_hs_state_e;

   localparam int DEF_DATA_W      = 8;
   localparam int DEF_SYNC_STAGES = 2;
   localparam int DEF_TIMEOUT     = 255;

   // A disabled timeout (0) still needs a one-bit counter to keep the vectors legal.
   function automatic int cnt_width(input int timeout);
      return (timeout < 1) ? 1 : $clog2(timeout + 1);
   endfunction

endpackage

// File: rtl/cdc_bit_sync.sv
// Multi-flop single-bit synchronizer; resets to 0.
// Reused for every level crossing into a clock domain.
module cdc_bit_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_q <= '0;
      else        sync_q <= {sync_q[STAGES-2:0], d};
   end

   assign q = sync_q[STAGES-1];

endmodule

// File: rtl/cdc_hs_src_ctrl.sv
// Source side of a four-phase req/ack crossing: captures one word per transfer,
// raises req, waits for ack high then low, and traps into ERR on a stalled phase.
module cdc_hs_src_ctrl
   import cdc_hs_pkg::*;
#(
   parameter int DATA_W      = DEF_DATA_W,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int TIMEOUT     = DEF_TIMEOUT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              src_valid,
   input  logic [DATA_W-1:0] src_data,
   output logic              src_ready,
   output logic              xfer_req,
   output logic [DATA_W-1:0] xfer_data,
   input  logic              xfer_ack_async,
   output logic              done,
   output logic              busy,
   output logic              timeout_err,
   input  logic              err_clear
);

   localparam int CNT_W = cnt_width(TIMEOUT);
   // Leaving on cnt==TIMEOUT-1 makes the phase last exactly TIMEOUT cycles.
   localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   cdc_hs_state_e     state, state_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic [DATA_W-1:0] xfer_data_nxt;
   logic              done_nxt;
   logic              at_limit;
   logic              ack_s;

   cdc_bit_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (xfer_ack_async),
      .q     (ack_s)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         xfer_data   <= '0;
         xfer_req    <= 1'b0;
         done        <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         xfer_data   <= xfer_data_nxt;
         xfer_req    <= (state_nxt == REQ);
         done        <= done_nxt;
         timeout_err <= (state_nxt == ERR);
      end
   end

   always_comb begin
      state_nxt     = state;
      xfer_data_nxt = xfer_data;
      done_nxt      = 1'b0;
      src_ready     = (state == IDLE) && !ack_s;
      busy          = (state != IDLE);
      at_limit      = (TIMEOUT != 0) && (cnt == CNT_LIM);

      // Ack is tested before the limit so a same-cycle ack wins.
      case (state)
         IDLE: if (src_valid && src_ready) begin
            state_nxt     = REQ;
            xfer_data_nxt = src_data;
         end
         REQ: begin
            if (ack_s)         state_nxt = RELEASE;
            else if (at_limit) state_nxt = ERR;
         end
         RELEASE: begin
            if (!ack_s) begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
            end else if (at_limit) begin
               state_nxt = ERR;
            end
         end
         ERR: if (err_clear && !ack_s) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase

      if (state_nxt != state)
         cnt_nxt = '0;
      else if (((state == REQ) || (state == RELEASE)) && (cnt != CNT_MAX))
         cnt_nxt = cnt + 1'b1;
      else
         cnt_nxt = cnt;
   end

endmodule

// File: tb/tb_cdc_hs_src_ctrl.sv
// Directed bench for cdc_hs_src_ctrl (DATA_W=8, SYNC_STAGES=2, TIMEOUT=16).
// Negedge index n counts posedges since the fire edge (n=1 right after it).
module tb_cdc_hs_src_ctrl;

   localparam int DW = 8;
   localparam int SS = 2;
   localparam int TO = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          src_valid = 1'b0;
   logic [DW-1:0] src_data = '0;
   logic          err_clear = 1'b0;
   logic          ack_force = 1'b0;
   logic          src_ready, xfer_req, done, busy, timeout_err;
   logic [DW-1:0] xfer_data;
   logic          xfer_ack_async;
   logic [2:0]    ack_dly = '0;
   int            dest_mode = 0;   // 0: forced level, 1: mirror req after 3 cycles, 2: mirror immediately
   int            checks = 0;
   int            passed = 0;

   always #5 clk = ~clk;

   always @(posedge clk) ack_dly <= {ack_dly[1:0], xfer_req};

   always_comb begin
      xfer_ack_async = ack_force;
      if (dest_mode == 1)      xfer_ack_async = ack_dly[2];
      else if (dest_mode == 2) xfer_ack_async = xfer_req;
   end

   cdc_hs_src_ctrl #(.DATA_W(DW), .SYNC_STAGES(SS), .TIMEOUT(TO)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .src_valid      (src_valid),
      .src_data       (src_data),
      .src_ready      (src_ready),
      .xfer_req       (xfer_req),
      .xfer_data      (xfer_data),
      .xfer_ack_async (xfer_ack_async),
      .done           (done),
      .busy           (busy),
      .timeout_err    (timeout_err),
      .err_clear      (err_clear)
   );

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #2;
      checks++; if (xfer_req !== 1'b0) $display("FAIL rst_xfer_req: got %b want 0", xfer_req); else passed++;
      checks++; if (xfer_data !== 8'h00) $display("FAIL rst_xfer_data: got %h want 00", xfer_data); else passed++;
      checks++; if (done !== 1'b0) $display("FAIL rst_done: got %b want 0", done); else passed++;
      checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else passed++;
      checks++; if (timeout_err !== 1'b0) $display("FAIL rst_timeout_err: got %b want 0", timeout_err); else passed++;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++; if (src_ready !== 1'b1) $display("FAIL rst_src_ready: got %b want 1", src_ready); else passed++;
      tick();
      tick();
   endtask

   task automatic test_basic();
      int stable_bad = 0;
      int ndone = 0;
      int done_n = 0;
      dest_mode = 1;
      src_valid = 1'b1;
      src_data  = 8'hA5;
      checks++; if (src_ready !== 1'b1) $display("FAIL basic_ready_at_fire: got %b want 1", src_ready); else passed++;
      tick();
      src_valid = 1'b0;
      src_data  = 8'h5A;
      checks++; if ({xfer_req, busy, src_ready} !== 3'b110) $display("FAIL basic_req_entry: got req/busy/ready %b want 110", {xfer_req, busy, src_ready}); else passed++;
      for (int n = 1; n <= 30; n++) begin
         if (xfer_data !== 8'hA5) stable_bad++;
         if (done) begin
            ndone++;
            if (done_n == 0) done_n = n;
         end
         tick();
      end
      checks++; if (stable_bad != 0) $display("FAIL basic_data_stable: got %0d unstable cycles want 0", stable_bad); else passed++;
      checks++; if (ndone != 1) $display("FAIL basic_done_count: got %0d want 1", ndone); else passed++;
      checks++; if (done_n != 13) $display("FAIL basic_done_cycle: got %0d want 13", done_n); else passed++;
      checks++; if (src_ready !== 1'b1) $display("FAIL basic_ready_after: got %b want 1", src_ready); else passed++;
   endtask

   task automatic test_latency();
      int done_n = 0;
      dest_mode = 2;
      src_valid = 1'b1;
      src_data  = 8'h3C;
      tick();
      src_valid = 1'b0;
      for (int n = 1; n <= 20; n++) begin
         if (done && done_n == 0) done_n = n;
         tick();
      end
      checks++; if (done_n != 2 * SS + 3) $display("FAIL latency_done_cycle: got %0d want %0d", done_n, 2 * SS + 3); else passed++;
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] got [2];
      int            nd = 0;
      int            nf = 0;
      int            rdy_bad = 0;
      logic          fire;
      got[0] = '0;
      got[1] = '0;
      dest_mode = 1;
      src_valid = 1'b1;
      src_data  = 8'h01;
      for (int n = 0; n < 80; n++) begin
         fire = src_valid && src_ready;
         if (busy && src_ready) rdy_bad++;
         if (done) begin
            if (nd < 2) got[nd] = xfer_data;
            nd++;
         end
         tick();
         if (fire) begin
            nf++;
            if (src_data == 8'h01) src_data = 8'h02;
            else src_valid = 1'b0;
         end
      end
      src_valid = 1'b0;
      checks++; if (nf != 2) $display("FAIL b2b_fires: got %0d want 2", nf); else passed++;
      checks++; if (nd != 2) $display("FAIL b2b_done_count: got %0d want 2", nd); else passed++;
      checks++; if (got[0] !== 8'h01) $display("FAIL b2b_first_word: got %h want 01", got[0]); else passed++;
      checks++; if (got[1] !== 8'h02) $display("FAIL b2b_second_word: got %h want 02", got[1]); else passed++;
      checks++; if (rdy_bad != 0) $display("FAIL b2b_ready_while_busy: got %0d cycles want 0", rdy_bad); else passed++;
   endtask

   task automatic test_timeout();
      dest_mode = 0;
      ack_force = 1'b0;
      src_valid = 1'b1;
      src_data  = 8'h99;
      tick();
      src_valid = 1'b0;
      repeat (15) tick();
      checks++; if ({xfer_req, timeout_err} !== 2'b10) $display("FAIL to_before_limit: got req/err %b want 10", {xfer_req, timeout_err}); else passed++;
      tick();
      checks++; if ({xfer_req, timeout_err, busy} !== 3'b011) $display("FAIL to_err_entry: got req/err/busy %b want 011", {xfer_req, timeout_err, busy}); else passed++;
      ack_force = 1'b1;
      repeat (3) tick();
      err_clear = 1'b1;
      tick();
      err_clear = 1'b0;
      checks++; if ({timeout_err, busy} !== 2'b11) $display("FAIL to_clear_with_ack: got err/busy %b want 11", {timeout_err, busy}); else passed++;
      ack_force = 1'b0;
      repeat (3) tick();
      err_clear = 1'b1;
      tick();
      err_clear = 1'b0;
      checks++; if ({timeout_err, busy, src_ready} !== 3'b001) $display("FAIL to_clear: got err/busy/ready %b want 001", {timeout_err, busy, src_ready}); else passed++;
   endtask

   task automatic test_ack_at_limit();
      int seen_done = 0;
      dest_mode = 0;
      ack_force = 1'b0;
      src_valid = 1'b1;
      src_data  = 8'h42;
      tick();
      src_valid = 1'b0;
      repeat (13) tick();
      ack_force = 1'b1;
      tick();
      tick();
      checks++; if (xfer_req !== 1'b1) $display("FAIL lim_req_held: got %b want 1", xfer_req); else passed++;
      tick();
      checks++; if ({xfer_req, timeout_err, busy} !== 3'b001) $display("FAIL lim_release: got req/err/busy %b want 001", {xfer_req, timeout_err, busy}); else passed++;
      ack_force = 1'b0;
      for (int n = 0; n < 10; n++) begin
         if (done) seen_done++;
         tick();
      end
      checks++; if (seen_done != 1) $display("FAIL lim_done: got %0d pulses want 1", seen_done); else passed++;
      checks++; if ({timeout_err, busy} !== 2'b00) $display("FAIL lim_idle: got err/busy %b want 00", {timeout_err, busy}); else passed++;
   endtask

   task automatic test_stale_ack();
      int bad = 0;
      int waited = 0;
      dest_mode = 0;
      rst_n = 1'b0;
      ack_force = 1'b1;
      tick();
      rst_n = 1'b1;
      #1;
      checks++; if (src_ready !== 1'b1) $display("FAIL stale_ready_pre_sync: got %b want 1", src_ready); else passed++;
      @(negedge clk);
      tick();
      checks++; if (src_ready !== 1'b0) $display("FAIL stale_ready_low: got %b want 0", src_ready); else passed++;
      src_valid = 1'b1;
      src_data  = 8'h77;
      for (int n = 0; n < 5; n++) begin
         if (src_ready || busy || xfer_req) bad++;
         tick();
      end
      checks++; if (bad != 0) $display("FAIL stale_no_start: got %0d bad cycles want 0", bad); else passed++;
      ack_force = 1'b0;
      src_valid = 1'b0;
      while (!src_ready && waited < 6) begin
         tick();
         waited++;
      end
      checks++; if ({src_ready, busy} !== 2'b10) $display("FAIL stale_ready_return: got ready/busy %b want 10 after %0d cycles", {src_ready, busy}, waited); else passed++;
      checks++; if (xfer_data !== 8'h00) $display("FAIL stale_no_capture: got %h want 00", xfer_data); else passed++;
   endtask

   task automatic test_reset_mid_req();
      dest_mode = 0;
      ack_force = 1'b0;
      src_valid = 1'b1;
      src_data  = 8'hC3;
      tick();
      src_valid = 1'b0;
      tick();
      checks++; if (xfer_req !== 1'b1) $display("FAIL mid_req_before: got %b want 1", xfer_req); else passed++;
      rst_n = 1'b0;
      #1;
      checks++; if ({xfer_req, busy} !== 2'b00) $display("FAIL mid_req_async_drop: got req/busy %b want 00", {xfer_req, busy}); else passed++;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++; if (xfer_data !== 8'h00) $display("FAIL mid_req_data: got %h want 00", xfer_data); else passed++;
      checks++; if ({src_ready, busy, done, timeout_err} !== 4'b1000) $display("FAIL mid_req_outputs: got ready/busy/done/err %b want 1000", {src_ready, busy, done, timeout_err}); else passed++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_latency();
      test_back_to_back();
      test_timeout();
      test_ack_at_limit();
      test_stale_ack();
      test_reset_mid_req();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit, %0d/%0d done", passed, checks);
      $fatal(1);
   end

endmodule
